// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_pkg
// Brief   : State encodings and frame field widths for the boot-time loader.
// Revision: 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_wport.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader_wport
// Brief   : One-stage register for the RAM write strobe, address and data.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader_wport #(
    parameter int            AW       = 12,
    parameter logic [AW-1:0] ADDR_RST = '0
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    data_i,
    output logic          we_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    data_o
);

    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;

    // Address and data hold their last written values between writes.
    always_ff @(posedge clk) begin
        if (rs) begin
            we_q   <= 1'b0;
            addr_q <= ADDR_RST;
            data_q <= 8'h00;
        end else begin
            we_q <= wr_i;
            if (wr_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Framed byte-stream loader for the instruction RAM; holds the CPU
//           until a program has loaded and passed its XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AW   = 12,
    parameter int BASE = 0
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [BYTE_W-1:0] mem_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LEN_W-1:0]  count_o
);

    localparam logic [AW-1:0] c_BASE_A  = AW'(BASE);
    localparam int unsigned   c_MAX_LEN = (32'd1 << AW) - 32'(BASE);

    state_t              state_q,    state_d;
    logic [LEN_W-1:0]    length_q,   length_d;
    logic [LEN_W-1:0]    count_q,    count_d;
    logic [BYTE_W-1:0]   csum_q,     csum_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q,     done_d;
    logic                error_q,    error_d;

    logic                w_ready;
    logic                w_xfer;
    logic                w_wr;
    logic [LEN_W-1:0]    w_len_full;
    logic [LEN_W-1:0]    w_count_inc;
    logic [AW-1:0]       w_wr_addr;

    assign w_ready     = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                         (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign w_xfer      = in_valid_i & w_ready;
    assign w_len_full  = {length_q[LEN_W-1:BYTE_W], in_data_i};
    assign w_count_inc = count_q + 16'd1;
    assign w_wr_addr   = c_BASE_A + count_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q    <= ST_LEN_HI;
            length_q   <= '0;
            count_q    <= '0;
            csum_q     <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            count_q    <= count_d;
            csum_q     <= csum_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        count_d    = count_q;
        csum_d     = csum_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        w_wr       = 1'b0;

        case (state_q)
            ST_LEN_HI: begin
                if (w_xfer) begin
                    length_d[LEN_W-1:BYTE_W] = in_data_i;
                    state_d                  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    length_d[BYTE_W-1:0] = in_data_i;
                    // Oversized frames fail here, before any RAM write.
                    if (w_len_full == '0) begin
                        state_d = ST_CSUM;
                    end else if ({16'd0, w_len_full} > c_MAX_LEN) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_wr    = 1'b1;
                    count_d = w_count_inc;
                    csum_d  = csum_q ^ in_data_i;
                    if (w_count_inc == length_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_xfer) begin
                    if (in_data_i == csum_q) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d    = ST_LEN_HI;
                    length_d   = '0;
                    count_d    = '0;
                    csum_d     = '0;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_LEN_HI;
            end
        endcase
    end

    imem_loader_wport #(
        .AW       (AW),
        .ADDR_RST (c_BASE_A)
    ) u_wport (
        .clk    (clk),
        .rs     (rs),
        .wr_i   (w_wr),
        .addr_i (w_wr_addr),
        .data_i (in_data_i),
        .we_o   (mem_we_o),
        .addr_o (mem_addr_o),
        .data_o (mem_data_o)
    );

    assign in_ready_o = w_ready;
    assign cpu_hold_o = cpu_hold_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign count_o    = count_q;

endmodule
`default_nettype wire
